// File: rtl/freq_tdm_deframer.sv
// Frame-alignment tracker and 4-slot TDM de-interleaver for the frequency-domain stream.
// Hunts for tfram, confirms alignment over LOCK_GOOD frames, and flywheels through missing headers.
module freq_tdm_deframer #(
    parameter int FRAME_LEN = 30720,
    parameter int LOCK_GOOD = 3,
    parameter int LOSS_BAD  = 4
) (
    input  logic        clk,
    input  logic        asy_rst,
    input  logic        i_freq_txant,
    input  logic [31:0] i_freq_tdata,
    input  logic        i_freq_tfram,
    input  logic        i_err_clr,
    output logic        o_vld,
    output logic [31:0] o_data,
    output logic [2:0]  o_ant_idx,
    output logic        o_fram_hd,
    output logic        o_lock,
    output logic [15:0] o_err_cnt
);
    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    localparam logic [19:0] LAST   = 20'(FRAME_LEN - 1);
    localparam logic [19:0] WMAX   = 20'hFFFFF;
    localparam logic [3:0]  GOOD_N = 4'(LOCK_GOOD);
    localparam logic [3:0]  BAD_N  = 4'(LOSS_BAD);

    state_t      state, state_nxt;
    logic [19:0] wcnt, wcnt_nxt;
    logic [3:0]  good_cnt, good_nxt, good_inc;
    logic [3:0]  bad_cnt, bad_nxt, bad_inc;
    logic        at_end, good_b, early, late;
    logic        accept, fly, err_inc, vld_nxt;

    // wcnt holds the index of the previous word, so a header is due when it reads LAST
    assign at_end   = (wcnt == LAST);
    assign good_b   = i_freq_tfram && at_end;
    assign early    = i_freq_tfram && !at_end;
    assign late     = !i_freq_tfram && at_end;
    assign good_inc = good_cnt + 4'd1;
    assign bad_inc  = bad_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        accept    = 1'b0;
        fly       = 1'b0;
        err_inc   = 1'b0;
        case (state)
            HUNT: begin
                if (i_freq_tfram) begin
                    state_nxt = CHECK;
                    accept    = 1'b1;
                    good_nxt  = 4'd0;
                end
            end
            CHECK: begin
                accept = i_freq_tfram;
                if (good_b) begin
                    good_nxt = good_inc;
                    if (good_inc == GOOD_N) state_nxt = LOCK;
                end else if (early) begin
                    err_inc  = 1'b1;
                    good_nxt = 4'd0;
                end else if (late) begin
                    err_inc   = 1'b1;
                    state_nxt = HUNT;
                end
            end
            LOCK: begin
                accept  = i_freq_tfram;
                fly     = late;
                err_inc = early || late;
                if (good_b) begin
                    bad_nxt = 4'd0;
                end else if (early || late) begin
                    if (bad_inc == BAD_N) begin
                        state_nxt = HUNT;
                        bad_nxt   = 4'd0;
                        good_nxt  = 4'd0;
                    end else begin
                        bad_nxt = bad_inc;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // A flywheel boundary restarts the count exactly like a received header
    assign wcnt_nxt = (accept || fly) ? 20'd0 :
                      (wcnt == WMAX)  ? wcnt  : wcnt + 20'd1;
    assign vld_nxt  = (state_nxt == LOCK);

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            state     <= HUNT;
            wcnt      <= 20'd0;
            good_cnt  <= 4'd0;
            bad_cnt   <= 4'd0;
            o_vld     <= 1'b0;
            o_data    <= 32'd0;
            o_ant_idx <= 3'd0;
            o_fram_hd <= 1'b0;
            o_lock    <= 1'b0;
            o_err_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            o_vld     <= vld_nxt;
            o_data    <= i_freq_tdata;
            o_ant_idx <= {i_freq_txant, wcnt_nxt[1:0]};
            o_fram_hd <= vld_nxt && (accept || fly);
            o_lock    <= vld_nxt;
            if (i_err_clr)
                o_err_cnt <= err_inc ? 16'd1 : 16'd0;
            else if (err_inc && o_err_cnt != 16'hFFFF)
                o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_freq_tdm_deframer.sv
// Randomized and directed bench for freq_tdm_deframer against a frame-position reference model.
module tb_freq_tdm_deframer;
    localparam int FL = 16;
    localparam int LG = 3;
    localparam int LB = 4;

    logic        clk = 1'b0;
    logic        asy_rst = 1'b1;
    logic        txant = 1'b0;
    logic [31:0] tdata = 32'd0;
    logic        tfram = 1'b0;
    logic        err_clr = 1'b0;
    logic        o_vld, o_fram_hd, o_lock;
    logic [31:0] o_data;
    logic [2:0]  o_ant_idx;
    logic [15:0] o_err_cnt;

    freq_tdm_deframer #(.FRAME_LEN(FL), .LOCK_GOOD(LG), .LOSS_BAD(LB)) dut (
        .clk(clk), .asy_rst(asy_rst), .i_freq_txant(txant), .i_freq_tdata(tdata),
        .i_freq_tfram(tfram), .i_err_clr(err_clr), .o_vld(o_vld), .o_data(o_data),
        .o_ant_idx(o_ant_idx), .o_fram_hd(o_fram_hd), .o_lock(o_lock), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: aligned-ness is a mode (searching / confirming / tracking) plus
    // the position of the last word inside the frame it believes in.
    int          m_mode;   // 0 searching, 1 confirming, 2 tracking
    int          m_pos;
    int          m_good, m_bad, m_err;
    logic [53:0] exp_v;
    logic [53:0] act;
    assign act = {o_vld, o_fram_hd, o_lock, o_ant_idx, o_err_cnt, o_data};

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0;
        exp_v = '0;
    endtask

    task automatic model_step(input bit tf, input bit ant, input logic [31:0] d, input bit clr);
        bit hdr, bad, due;
        int nmode;
        logic [15:0] e16;
        logic [19:0] p20;
        hdr = 0; bad = 0; nmode = m_mode;
        due = (m_pos == FL - 1);
        if (m_mode == 0) begin
            if (tf) begin nmode = 1; hdr = 1; m_good = 0; end
        end else if (m_mode == 1) begin
            if (tf) begin
                hdr = 1;
                if (due) begin
                    m_good++;
                    if (m_good == LG) nmode = 2;
                end else begin
                    bad = 1; m_good = 0;
                end
            end else if (due) begin
                bad = 1; nmode = 0;
            end
        end else begin
            if (tf || due) hdr = 1;
            if (tf && due) m_bad = 0;
            else if (tf || due) begin
                bad = 1; m_bad++;
                if (m_bad == LB) begin nmode = 0; m_bad = 0; m_good = 0; end
            end
        end
        m_mode = nmode;
        if (hdr) m_pos = 0;
        else if (m_pos < 20'hFFFFF) m_pos++;
        if (clr) m_err = bad ? 1 : 0;
        else if (bad && m_err < 65535) m_err++;
        e16 = 16'(m_err);
        p20 = 20'(m_pos);
        exp_v = {m_mode == 2, (m_mode == 2) && hdr, m_mode == 2, ant, p20[1:0], e16, d};
    endtask

    task automatic tick(input bit tf, input bit ant, input logic [31:0] d, input bit clr);
        tfram = tf; txant = ant; tdata = d; err_clr = clr;
        model_step(tf, ant, d, clr);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        asy_rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (act !== 54'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", act);
        end
        @(posedge clk); #1;
        asy_rst = 1'b0;
        n_tests++;
        if (act !== 54'd0) begin
            n_fail++; $display("FAIL reset_release got=%h exp=0", act);
        end
    endtask

    task automatic test_acquire();
        int first = -1;
        bit hd_first = 0;
        logic [11:0] ants = '0;
        for (int w = 0; w < 5 * FL; w++) begin
            tick(w % FL == 0, 1'b1, 32'(w), 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL acquire w=%0d got=%h exp=%h", w, act, exp_v);
            end
            if (o_vld && first < 0) begin first = w; hd_first = o_fram_hd; end
            if (w >= 48 && w < 52) ants = {ants[8:0], o_ant_idx};
        end
        n_tests++;
        if (first !== 48 || hd_first !== 1'b1) begin
            n_fail++; $display("FAIL acquire_first_vld got=%0d/%0b exp=48/1", first, hd_first);
        end
        n_tests++;
        if (ants !== 12'b100_101_110_111) begin
            n_fail++; $display("FAIL acquire_ant_seq got=%b exp=100101110111", ants);
        end
        n_tests++;
        if (o_err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL acquire_err got=%0d exp=0", o_err_cnt);
        end
    endtask

    task automatic test_flywheel();
        for (int k = 0; k < 3 * FL; k++) begin
            tick(k == 16 || k == 32, 1'b0, $urandom, k == 40);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL flywheel k=%0d got=%h exp=%h", k, act, exp_v);
            end
            if (k == 0) begin
                n_tests++;
                if ({o_vld, o_fram_hd, o_err_cnt} !== {2'b11, 16'd1}) begin
                    n_fail++; $display("FAIL flywheel_hd got=%b%b/%0d exp=11/1", o_vld, o_fram_hd, o_err_cnt);
                end
            end
            if (k == 16) begin
                n_tests++;
                if ({o_vld, o_fram_hd, o_err_cnt} !== {2'b11, 16'd1}) begin
                    n_fail++; $display("FAIL flywheel_good got=%b%b/%0d exp=11/1", o_vld, o_fram_hd, o_err_cnt);
                end
            end
            if (k == 40) begin
                n_tests++;
                if (o_err_cnt !== 16'd0) begin
                    n_fail++; $display("FAIL err_clr_alone got=%0d exp=0", o_err_cnt);
                end
            end
        end
    endtask

    task automatic test_loss();
        int hd_cnt = 0;
        int drop = -1;
        for (int k = 0; k < 5 * FL; k++) begin
            tick(1'b0, $urandom_range(0, 1), $urandom, 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL loss k=%0d got=%h exp=%h", k, act, exp_v);
            end
            if (o_vld && o_fram_hd) hd_cnt++;
            if (!o_lock && drop < 0) drop = k;
        end
        n_tests++;
        if (hd_cnt !== 3 || drop !== 48) begin
            n_fail++; $display("FAIL loss_drop got=%0d/%0d exp=3/48", hd_cnt, drop);
        end
        n_tests++;
        if (o_err_cnt !== 16'd4) begin
            n_fail++; $display("FAIL loss_err got=%0d exp=4", o_err_cnt);
        end
    endtask

    task automatic test_early();
        int first = -1;
        for (int k = 0; k < 90; k++) begin
            tick(k == 0 || k == 16 || (k >= 26 && (k - 26) % FL == 0), $urandom_range(0, 1), $urandom, 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL early k=%0d got=%h exp=%h", k, act, exp_v);
            end
            if (k == 26) begin
                n_tests++;
                if ({o_vld, o_err_cnt} !== {1'b0, 16'd5}) begin
                    n_fail++; $display("FAIL early_err got=%b/%0d exp=0/5", o_vld, o_err_cnt);
                end
            end
            if (o_vld && first < 0) first = k;
        end
        n_tests++;
        if (first !== 74) begin
            n_fail++; $display("FAIL early_relock got=%0d exp=74", first);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 65600; k++) begin
            tick(1'b1, $urandom_range(0, 1), $urandom, 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL saturate k=%0d got=%h exp=%h", k, act, exp_v);
            end
        end
        n_tests++;
        if (o_err_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL saturate_hold got=%h exp=ffff", o_err_cnt);
        end
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        n_tests++;
        if (o_err_cnt !== 16'd1) begin
            n_fail++; $display("FAIL clr_with_err got=%0d exp=1", o_err_cnt);
        end
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        n_tests++;
        if (o_err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clr_no_err got=%0d exp=0", o_err_cnt);
        end
    endtask

    task automatic test_random();
        int phase = 0;
        bit tf;
        for (int k = 0; k < 3000; k++) begin
            tf = (phase == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 63) == 0);
            if (tf) phase = 0;
            tick(tf, $urandom_range(0, 1), $urandom, $urandom_range(0, 49) == 0);
            phase = (phase + 1) % FL;
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL random k=%0d got=%h exp=%h", k, act, exp_v);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int first = -1;
        for (int k = 0; k < 10 * FL + 7; k++) begin
            tick(k % FL == 0, 1'b1, $urandom, 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, act, exp_v);
            end
        end
        n_tests++;
        if (o_lock !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_lock got=%b exp=1", o_lock);
        end
        tfram = 1'b0;
        #2 asy_rst = 1'b1;
        #1;
        n_tests++;
        if (act !== 54'd0) begin
            n_fail++; $display("FAIL midframe_reset got=%h exp=0", act);
        end
        @(posedge clk); #1;
        asy_rst = 1'b0;
        model_reset();
        for (int k = 0; k < 64; k++) begin
            tick(k >= 3 && (k - 3) % FL == 0, 1'b0, $urandom, 1'b0);
            n_tests++;
            if (act !== exp_v) begin
                n_fail++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, act, exp_v);
            end
            if (o_vld && first < 0) first = k;
        end
        n_tests++;
        if (first !== 51) begin
            n_fail++; $display("FAIL post_reset_relock got=%0d exp=51", first);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_flywheel();
        test_loss();
        test_early();
        test_saturate();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
